// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the 4-bit ALU control codes, FSM state constants, shift-kind
// encoding and small opcode classification helpers.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Shift kind handed to the iterative shifter
    typedef logic [1:0] shift_kind_t;
    localparam shift_kind_t SH_SLL = 2'd0;
    localparam shift_kind_t SH_SRL = 2'd1;
    localparam shift_kind_t SH_SRA = 2'd2;

    // True for the three shift opcodes
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

    // Map a shift opcode onto the shifter's kind encoding
    function automatic shift_kind_t shift_kind(input logic [3:0] op);
        shift_kind_t k;
        case (op)
            ALU_SRA: k = SH_SRA;
            ALU_SRL: k = SH_SRL;
            default: k = SH_SLL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - load operand/shamt/kind (only asserted with shamt > 0)
//   operand   - value to shift
//   shamt     - number of bit positions to shift
//   kind      - SLL / SRL / SRA
//   done      - combinational: the shift applied this cycle is the last one
//   value     - combinational: shift register after this cycle's step
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [XLEN-1:0]          operand,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  shift_kind_t              kind,
    output logic                     done,
    output logic [XLEN-1:0]          value
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] sh_q;
    logic [SHW-1:0]  cnt_q;
    shift_kind_t     kind_q;
    logic [XLEN-1:0] step;

    // One-position shift of the current register contents
    always_comb begin
        step = sh_q;
        case (kind_q)
            SH_SLL:  step = {sh_q[XLEN-2:0], 1'b0};
            SH_SRL:  step = {1'b0, sh_q[XLEN-1:1]};
            SH_SRA:  step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
            default: step = sh_q;
        endcase
    end

    // Shift register and down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            kind_q <= SH_SLL;
        end else if (start) begin
            sh_q   <= operand;
            cnt_q  <= shamt;
            kind_q <= kind;
        end else if (cnt_q != '0) begin
            sh_q  <= step;
            cnt_q <= cnt_q - SHW'(1);
        end
    end

    // Counter at 1 means this cycle's step completes the shift
    assign done  = (cnt_q == SHW'(1));
    assign value = step;

endmodule

// File: rtl/alu_iter.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Logic, add/sub and compare ops complete in one cycle; shifts run one bit
// per cycle through alu_shift_iter unless ALU_FAST_SHIFT_EN is defined, in
// which case a combinational shifter is used and no SHIFT state exists.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operation handshake (in_ready is combinational)
//   alu_ctrl            - 4-bit operation code
//   src_a, src_b        - operands; shift amount is src_b[SHW-1:0]
//   out_valid, out_ready- result handshake
//   result, zero        - registered result and result==0 flag
//   illegal             - completed op had an undefined code
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_t          state;
    state_t          state_nxt;
    logic            out_valid_nxt;
    logic [XLEN-1:0] result_nxt;
    logic            zero_nxt;
    logic            illegal_nxt;

    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            iter_shift;
    logic            shift_start;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    assign shamt  = src_b[SHW-1:0];
    assign accept = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign in_ready   = !out_valid || out_ready;
    assign iter_shift = 1'b0;
`else
    assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    // Only non-zero shifts need the multi-cycle path
    assign iter_shift = is_shift(alu_ctrl) && (shamt != '0);
`endif

    // Single-cycle datapath; in the iterative build a shift only reaches
    // here with shamt == 0, so it passes src_a through unchanged
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            ALU_OR:   alu_res = src_a | src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
`else
            ALU_SLL:  alu_res = src_a;
            ALU_SRL:  alu_res = src_a;
            ALU_SRA:  alu_res = src_a;
`endif
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic            shift_done;
    logic [XLEN-1:0] shift_value;

    alu_shift_iter #(
        .XLEN (XLEN)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (shift_start),
        .operand (src_a),
        .shamt   (shamt),
        .kind    (shift_kind(alu_ctrl)),
        .done    (shift_done),
        .value   (shift_value)
    );
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        result_nxt    = result;
        illegal_nxt   = illegal;
        shift_start   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if ((state == ST_DONE) && out_ready) begin
                    state_nxt     = ST_IDLE;
                    out_valid_nxt = 1'b0;
                end
                // Accept may coincide with consumption (back-to-back)
                if (accept) begin
                    if (iter_shift) begin
                        shift_start   = 1'b1;
                        state_nxt     = ST_SHIFT;
                        out_valid_nxt = 1'b0;
                    end else begin
                        result_nxt    = alu_res;
                        illegal_nxt   = alu_ill;
                        state_nxt     = ST_DONE;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: begin
                if (shift_done) begin
                    result_nxt    = shift_value;
                    illegal_nxt   = 1'b0;
                    state_nxt     = ST_DONE;
                    out_valid_nxt = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign zero_nxt = (result_nxt == '0);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            result    <= result_nxt;
            zero      <= zero_nxt;
            illegal   <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: a queue-based reference model checked
// every cycle, plus directed vectors with literal expected values.
// Build with ALU_FAST_SHIFT_EN defined to exercise the fast-shift variant.
module tb_alu_iter;

    localparam int unsigned XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    alu_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour: what an accepted op must produce and when
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int k;
        k   = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a | b;
            4'd1: r = a & b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd4: r = a << k;
            4'd5: r = $signed(a) >>> k;
            4'd6: r = a - b;
            4'd7: r = a >> k;
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if (!FAST && (op == 4'd4 || op == 4'd5 || op == 4'd7) && k != 0) lat = k + 1;
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic        v_exp;
    logic        r_exp;
    logic [31:0] m_res;
    logic        m_ill;
    int          m_lat;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            v_exp = (q.size() > 0) && (cyc >= q[0].due);
            r_exp = (q.size() == 0) || (v_exp && out_ready);
            check("out_valid", 32'(out_valid), 32'(v_exp));
            check("in_ready", 32'(in_ready), 32'(r_exp));
            if (v_exp) begin
                check("result", result, q[0].res);
                check("zero", 32'(zero), 32'(q[0].res == 32'd0));
                check("illegal", 32'(illegal), 32'(q[0].ill));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && r_exp) begin
                model(alu_ctrl, src_a, src_b, m_res, m_ill, m_lat);
                q.push_back('{res: m_res, ill: m_ill, due: cyc + m_lat});
            end
        end
    end

    // Offer one op, wait for its result with out_ready high
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic ill, output logic z, output int lat);
        bit acc;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        r = '0; ill = 1'b0; z = 1'b0; lat = -1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
        alu_ctrl = 4'($urandom);
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                r   = result;
                ill = illegal;
                z   = zero;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) check("result_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] r;
    logic        ill;
    logic        z;
    int          lat;
    int          seen;
    logic [31:0] b2b_a [3];
    logic [31:0] b2b_b [3];
    logic [3:0]  b2b_op[3];
    logic [31:0] b2b_r [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        send(4'b0010, 32'hFFFF_FFFF, 32'd1, r, ill, z, lat);
        check("add_res", r, 32'd0);
        check("add_zero", 32'(z), 32'd1);
        check("add_lat", 32'(lat), 32'd1);

        send(4'b0101, 32'h8000_0000, 32'd4, r, ill, z, lat);
        check("sra_res", r, 32'hF800_0000);
        check("sra_lat", 32'(lat), FAST ? 32'd1 : 32'd5);

        send(4'b0111, 32'h8000_0000, 32'd4, r, ill, z, lat);
        check("srl_res", r, 32'h0800_0000);
        check("srl_lat", 32'(lat), FAST ? 32'd1 : 32'd5);

        send(4'b1000, 32'hFFFF_FFFF, 32'd1, r, ill, z, lat);
        check("slt_res", r, 32'd1);
        send(4'b1001, 32'hFFFF_FFFF, 32'd1, r, ill, z, lat);
        check("sltu_res", r, 32'd0);
        send(4'b1111, 32'h1234_5678, 32'd9, r, ill, z, lat);
        check("undef_res", r, 32'd0);
        check("undef_illegal", 32'(ill), 32'd1);

        send(4'b0110, 32'd5, 32'd7, r, ill, z, lat);
        check("sub_res", r, 32'hFFFF_FFFE);
        check("sub_illegal", 32'(ill), 32'd0);

        // Maximum shift amount
        send(4'b0100, 32'd1, 32'd31, r, ill, z, lat);
        check("sll31_res", r, 32'h8000_0000);
        check("sll31_lat", 32'(lat), FAST ? 32'd1 : 32'd32);

        // Only the low SHW bits of src_b count as shift amount
        send(4'b0100, 32'h1234, 32'h20, r, ill, z, lat);
        check("sll_wrap_res", r, 32'h1234);
        check("sll_wrap_lat", 32'(lat), 32'd1);

        // Back-to-back non-shift ops, then consumer stall
        b2b_op[0] = 4'b0000; b2b_a[0] = 32'hF0; b2b_b[0] = 32'h0F; b2b_r[0] = 32'hFF;
        b2b_op[1] = 4'b0001; b2b_a[1] = 32'hFF; b2b_b[1] = 32'h3C; b2b_r[1] = 32'h3C;
        b2b_op[2] = 4'b0011; b2b_a[2] = 32'hFF; b2b_b[2] = 32'h0F; b2b_r[2] = 32'hF0;
        for (int k = 0; k < 3; k++) begin
            alu_ctrl = b2b_op[k]; src_a = b2b_a[k]; src_b = b2b_b[k]; in_valid = 1'b1;
            @(negedge clk);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            if (k > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_res", result, b2b_r[k-1]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        alu_ctrl = 4'b0010; src_a = 32'd2; src_b = 32'd3;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_res", result, 32'hF0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_res", result, 32'hF0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("after_stall_valid", 32'(out_valid), 32'd1);
        check("after_stall_res", result, 32'd5);
        @(posedge clk); #1;

        // Reset in the middle of a long shift
        alu_ctrl = 4'b0100; src_a = 32'h1; src_b = 32'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        @(posedge clk); #1;

        send(4'b0100, 32'h1234, 32'd0, r, ill, z, lat);
        check("sll0_res", r, 32'h1234);
        check("sll0_lat", 32'(lat), 32'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Registered execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder plus two XLEN-bit operands and produces a result and zero flag. Logic, add/sub and compare ops finish in one cycle. Shifts run iteratively, one bit position per cycle, to avoid a barrel shifter. A valid/ready handshake on both sides lets the core stall while a shift is in flight.

## Interface
- XLEN, 32, operand/result width; must be a power of two ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- alu_ctrl  in  4  operation code (see Operation)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B; shift amount is src_b[SHW-1:0]
- out_valid  out  1  result register holds a completed result
- out_ready  in  1  consumer takes result this cycle
- result  out  XLEN  registered result
- zero  out  1  result == 0
- illegal  out  1  completed op had an undefined code

## Operation
- Codes:
  - 0000 OR; 0001 AND; 0010 ADD; 0011 XOR.
  - 0100 SLL; 0101 SRA; 0110 SUB; 0111 SRL.
  - 1000 SLT (signed); 1001 SLTU.
  - All other codes are undefined: result = 0, illegal = 1.
- Arithmetic is modulo 2^XLEN; overflow is ignored. SLT/SLTU return 1 or 0, zero-extended.
- Handshake:
  - An operation is accepted on a cycle with in_valid && in_ready; operands and code are captured.
  - A result is consumed on a cycle with out_valid && out_ready.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept of a non-shift op, or a shift with shamt = 0: compute, load result, go to DONE.
  - IDLE, accept of a shift with shamt > 0: load the shift register with src_a and the counter with shamt, go to SHIFT.
  - SHIFT: each cycle shift by 1 (SLL: zero fill at LSB; SRL: zero fill at MSB; SRA: replicate MSB) and decrement the counter. When the counter reaches 1, the final shift is applied that same cycle and the state goes to DONE.
  - DONE: out_valid = 1 and result/zero/illegal are held stable. On out_ready, go to IDLE, or accept a new op in the same cycle (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Operands on src_a/src_b/alu_ctrl are don't-care except in the accept cycle.

## Timing
- Reset values: state = IDLE, out_valid = 0, result = 0, zero = 1, illegal = 0, counter = 0, in_ready = 1 (combinational from state) in the first cycle after reset.
- Non-shift op accepted at cycle N: out_valid = 1 at N+1.
- Shift with amount k > 0 accepted at N: out_valid = 1 at N+k+1. Maximum is N+XLEN.
- Throughput with out_ready held high: one non-shift op per cycle.
- Consumer stall (out_ready = 0 in DONE): outputs are held, in_ready = 0, no op is lost.
- rst asserted in any state, including mid-SHIFT: the next cycle is the reset state, the in-flight op is discarded, and no out_valid pulse occurs.
- in_valid in SHIFT is ignored (in_ready = 0).

## Configuration
- ALU_FAST_SHIFT_EN defined:
  - Shifts complete in one cycle via a combinational shifter, identical to other ops.
  - The SHIFT state and counter are not built.
  - in_ready = !out_valid || out_ready.
- Undefined: iterative shifter as described above.
- Results are bit-identical in both builds; only latency differs.

## Structure
- Shared package alu_pkg holds the 4-bit opcode localparams (ALU_OR … ALU_SLTU) and the FSM state enum. alu_decoder and alu_iter both import it.
- One sub-module, alu_shift_iter: owns the shift register and down-counter, with start/shamt/kind inputs and done/value outputs. It is omitted under ALU_FAST_SHIFT_EN.

## Test plan
- ADD: a = 0xFFFF_FFFF, b = 1, code 0010 -> result 0, zero = 1, out_valid one cycle after accept.
- SRA: a = 0x8000_0000, b = 4, code 0101 -> result 0xF800_0000 after 5 cycles; SRL with the same operands -> 0x0800_0000.
- SLT: a = 0xFFFF_FFFF, b = 1 -> 1; SLTU with the same operands -> 0; code 1111 -> result 0, illegal = 1.
- Back-to-back: 3 non-shift ops with out_ready held high -> 3 results on consecutive cycles. Then hold out_ready = 0 for 5 cycles -> result held, in_ready = 0.
- SLL with b = 31, rst pulsed at cycle 10 -> no out_valid, in_ready = 1 the cycle after reset. A following SLL with b = 0, a = 0x1234 -> 0x1234 after 1 cycle.
- Repeat all scenarios with ALU_FAST_SHIFT_EN defined -> same results, all latencies 1.
